// File: rtl/washer_pkg.sv
// washer_pkg: shared pattern/state encodings and default beep pattern lengths.
package washer_pkg;
  typedef enum logic [1:0] {
    PAT_NONE   = 2'd0,
    PAT_CLICK  = 2'd1,
    PAT_FINISH = 2'd2,
    PAT_ALARM  = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } st_e;

  localparam int DEF_TICK_DIV   = 500000;
  localparam int DEF_PHASE_W    = 8;
  localparam int DEF_CLICK_ON   = 5;
  localparam int DEF_FINISH_ON  = 50;
  localparam int DEF_FINISH_OFF = 30;
  localparam int DEF_FINISH_CNT = 3;
  localparam int DEF_ALARM_ON   = 20;
  localparam int DEF_ALARM_OFF  = 20;
endpackage

// File: rtl/beep_tick.sv
// beep_tick: clearable prescaler; tick is high on the last cycle of every DIV-cycle period.
module beep_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(DIV - 1);
  assign cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/beep_sequencer.sv
// beep_sequencer: plays click/finish/alarm on/off patterns on beep and beep_led.
// Define BEEP_TONE_EN to gate beep with a TONE_HALF square wave for a passive piezo.
module beep_sequencer
  import washer_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int CLICK_ON   = DEF_CLICK_ON,
  parameter int FINISH_ON  = DEF_FINISH_ON,
  parameter int FINISH_OFF = DEF_FINISH_OFF,
  parameter int FINISH_CNT = DEF_FINISH_CNT,
  parameter int ALARM_ON   = DEF_ALARM_ON,
  parameter int ALARM_OFF  = DEF_ALARM_OFF
`ifdef BEEP_TONE_EN
  , parameter int TONE_HALF = 12500
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       click_req,
  input  logic       finish_req,
  input  logic       alarm,
  output logic       beep,
  output logic       beep_led,
  output logic       busy,
  output logic [1:0] pattern
);
  st_e state_q, state_d;
  pat_e pat_q, pat_d, req;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic led_q, busy_q, tick, ending, to_on, to_off, free, start, clr;

  function automatic logic [PHASE_W-1:0] on_len(pat_e p);
    return p == PAT_CLICK ? PHASE_W'(CLICK_ON) : p == PAT_FINISH ? PHASE_W'(FINISH_ON) : PHASE_W'(ALARM_ON);
  endfunction

  function automatic logic [PHASE_W-1:0] off_len(pat_e p);
    return p == PAT_FINISH ? PHASE_W'(FINISH_OFF) : PHASE_W'(ALARM_OFF);
  endfunction

  beep_tick #(.DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .tick(tick)
  );

  // A request starts a pattern when the sequencer is free (idle or just ending) or outranks the active one.
  always_comb begin
    req = alarm ? PAT_ALARM : finish_req ? PAT_FINISH : click_req ? PAT_CLICK : PAT_NONE;
    ending = state_q != ST_IDLE && tick && phase_q == PHASE_W'(1);
    to_off = ending && state_q == ST_ON && (pat_q == PAT_FINISH ? bcnt_q > 3'd1 : pat_q == PAT_ALARM && alarm);
    to_on = ending && state_q == ST_OFF && (pat_q == PAT_FINISH || alarm);
    free = state_q == ST_IDLE || (ending && !to_off && !to_on);
    start = req != PAT_NONE && (free || req > pat_q);
    clr = start || to_on || to_off || free;
    state_d = (start || to_on) ? ST_ON : to_off ? ST_OFF : free ? ST_IDLE : state_q;
    pat_d = start ? req : free ? PAT_NONE : pat_q;
    phase_d = start ? on_len(req) : to_on ? on_len(pat_q) : to_off ? off_len(pat_q) :
              free ? '0 : tick ? phase_q - PHASE_W'(1) : phase_q;
    bcnt_d = start ? (req == PAT_FINISH ? 3'(FINISH_CNT) : 3'd1) :
             (to_off && pat_q == PAT_FINISH) ? bcnt_q - 3'd1 : free ? '0 : bcnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pat_q <= PAT_NONE;
      phase_q <= '0;
      bcnt_q <= '0;
      led_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      phase_q <= phase_d;
      bcnt_q <= bcnt_d;
      led_q <= state_d == ST_ON;
      busy_q <= state_d != ST_IDLE;
    end
  end

  assign beep_led = led_q;
  assign busy = busy_q;
  assign pattern = pat_q;

`ifdef BEEP_TONE_EN
  localparam int TW = $clog2(TONE_HALF + 1);
  logic tone_q;
  logic [TW-1:0] tcnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      tone_q <= 1'b0;
      tcnt_q <= '0;
    end else if (start || to_on) begin
      tone_q <= 1'b1;
      tcnt_q <= '0;
    end else if (tcnt_q == TW'(TONE_HALF - 1)) begin
      tone_q <= ~tone_q;
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + TW'(1);
    end
  end
  assign beep = led_q & tone_q;
`else
  assign beep = led_q;
`endif
endmodule

// File: tb/tb_beep_sequencer.sv
// tb_beep_sequencer: directed scenarios push per-cycle expected outputs; a negedge monitor pops and compares.
module tb_beep_sequencer;
  logic clk = 1'b0, reset = 1'b1, click_req = 1'b0, finish_req = 1'b0, alarm = 1'b0;
  logic beep, beep_led, busy;
  logic [1:0] pattern;

  typedef struct {
    logic [4:0] v;
    string      tag;
    int         idx;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int compared = 0, mismatched = 0, cyc = 0, pos = 0;
  string tag = "";

  always #5 clk = ~clk;

  beep_sequencer #(
    .TICK_DIV(4), .PHASE_W(8), .CLICK_ON(2), .FINISH_ON(3), .FINISH_OFF(2),
    .FINISH_CNT(3), .ALARM_ON(1), .ALARM_OFF(1)
`ifdef BEEP_TONE_EN
    , .TONE_HALF(2)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .click_req(click_req),
    .finish_req(finish_req),
    .alarm(alarm),
    .beep(beep),
    .beep_led(beep_led),
    .busy(busy),
    .pattern(pattern)
  );

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      compared++;
      if ({beep_led, busy, pattern, beep} !== e.v) begin
        mismatched++;
        $display("FAIL %s[%0d]: led/busy/pat/beep got %b required %b", e.tag, e.idx,
                 {beep_led, busy, pattern, beep}, e.v);
      end
    end
  end

  task automatic begin_scn(input string name);
    tag = name;
    pos = 0;
    cyc = 0;
  endtask

  task automatic seg(input int n, input logic led, input logic bsy, input logic [1:0] pat);
    for (int i = 0; i < n; i++) begin
      logic bp;
`ifdef BEEP_TONE_EN
      bp = led && (i % 4 < 2);
`else
      bp = led;
`endif
      q.push_back('{v: {led, bsy, pat, bp}, tag: tag, idx: pos});
      pos++;
    end
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic end_scn();
    go(pos);
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s drain: %0d expectations left, required 0", tag, q.size());
      q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    begin_scn("reset");
    seg(2, 0, 0, 0);
    go(2);
    reset = 1'b0;
    end_scn();

    begin_scn("click");
    seg(11, 0, 0, 0); seg(8, 1, 1, 1); seg(4, 0, 0, 0);
    go(10); click_req = 1'b1;
    go(11); click_req = 1'b0;
    end_scn();

    begin_scn("finish");
    seg(11, 0, 0, 0); seg(12, 1, 1, 2); seg(8, 0, 1, 2); seg(12, 1, 1, 2);
    seg(8, 0, 1, 2); seg(12, 1, 1, 2); seg(4, 0, 0, 0);
    go(10); finish_req = 1'b1;
    go(11); finish_req = 1'b0;
    end_scn();

    begin_scn("ignore_low");
    seg(3, 0, 0, 0); seg(12, 1, 1, 2); seg(8, 0, 1, 2); seg(12, 1, 1, 2);
    seg(8, 0, 1, 2); seg(12, 1, 1, 2); seg(4, 0, 0, 0);
    go(2); finish_req = 1'b1;
    go(3); finish_req = 1'b0;
    go(6); click_req = 1'b1;
    go(7); click_req = 1'b0;
    go(18); finish_req = 1'b1;
    go(19); finish_req = 1'b0;
    end_scn();

    begin_scn("alarm_preempt");
    seg(3, 0, 0, 0); seg(6, 1, 1, 2); seg(4, 1, 1, 3); seg(4, 0, 1, 3);
    seg(4, 1, 1, 3); seg(4, 0, 1, 3); seg(4, 1, 1, 3); seg(4, 0, 0, 0);
    go(2); finish_req = 1'b1;
    go(3); finish_req = 1'b0;
    go(8); alarm = 1'b1;
    go(15); finish_req = 1'b1;
    go(16); finish_req = 1'b0;
    go(26); alarm = 1'b0;
    end_scn();

    begin_scn("coincide_reset");
    seg(3, 0, 0, 0); seg(5, 1, 1, 2); seg(4, 0, 0, 0);
    go(2); click_req = 1'b1; finish_req = 1'b1;
    go(3); click_req = 1'b0; finish_req = 1'b0;
    go(7); reset = 1'b1;
    go(8); reset = 1'b0;
    end_scn();

    begin_scn("back2back");
    seg(3, 0, 0, 0); seg(8, 1, 1, 1); seg(12, 1, 1, 2); seg(8, 0, 1, 2);
    seg(12, 1, 1, 2); seg(8, 0, 1, 2); seg(12, 1, 1, 2); seg(4, 0, 0, 0);
    go(2); click_req = 1'b1;
    go(3); click_req = 1'b0;
    go(10); finish_req = 1'b1;
    go(11); finish_req = 1'b0;
    end_scn();

    begin_scn("alarm_idle_off_drop");
    seg(3, 0, 0, 0); seg(4, 1, 1, 3); seg(4, 0, 1, 3); seg(4, 0, 0, 0);
    go(2); alarm = 1'b1;
    go(8); alarm = 1'b0;
    end_scn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
